board_move_collector: RTL and testbench

BOARD_MOVE_COLLECTOR -- requirements
Module: board_move_collector

---
 rtl/board_move_collector.sv | 93 +++++++++
 tb/tb_board_move_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/board_move_collector.sv
// board_move_collector: drains eight column move FIFOs in column order 0..7 onto one ready/valid stream.
// Define COLLECT_TIMEOUT_EN to bound the wait on each column's done flag by TIMEOUT_CYCLES.
module board_move_collector #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter int MAX_MOVES = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   col_done,
  input  logic [383:0] col_data,
  output logic [7:0]   col_rden,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [47:0]  out_data,
  output logic [2:0]   out_col,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int CW = $clog2(MAX_MOVES + 1);
  typedef enum logic [2:0] {IDLE, SCAN, READ, CAPT, SEND, DONE} state_t;
  state_t r_state, w_next, w_adv_st;
  logic [2:0] r_ptr, r_col;
  logic [CW-1:0] r_cnt;
  logic [47:0] r_data, w_word;
  logic r_err, w_marker, w_hs, w_full, w_to, w_adv, w_start;
  assign w_word = col_data[48*r_ptr +: 48];
  // A move from a square to itself repeats the same 6-bit field eight times.
  assign w_marker = w_word == {8{w_word[5:0]}};
  assign w_hs = r_state == SEND && out_ready;
  assign w_full = r_cnt == CW'(MAX_MOVES - 1);
  assign w_start = (r_state == IDLE || r_state == DONE) && start;
`ifdef COLLECT_TIMEOUT_EN
  logic [15:0] r_to;
  always_ff @(posedge clk)
    if (reset || r_state != SCAN) r_to <= '0;
    else r_to <= r_to + 16'd1;
  assign w_to = r_state == SCAN && !col_done[r_ptr] && r_to == TIMEOUT_CYCLES - 16'd1;
`else
  // Without the timeout the parameter only keeps the interface uniform across builds.
  assign w_to = 1'b0 && TIMEOUT_CYCLES != 16'd0;
`endif
  assign w_adv = (r_state == CAPT && w_marker) || (w_hs && w_full) || w_to;
  assign w_adv_st = r_ptr == 3'd7 ? DONE : SCAN;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? SCAN : r_state;
      SCAN:       w_next = col_done[r_ptr] ? READ : w_to ? w_adv_st : SCAN;
      READ:       w_next = CAPT;
      CAPT:       w_next = w_marker ? w_adv_st : SEND;
      SEND:       w_next = out_ready ? (w_full ? w_adv_st : READ) : SEND;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
      r_col  <= '0;
    end else begin
      if (w_start) begin
        r_ptr <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (w_hs) r_cnt <= r_cnt + 1'b1;
      if (w_adv) begin
        r_ptr <= r_ptr + 3'd1;
        r_cnt <= '0;
      end
      if ((w_hs && w_full) || w_to) r_err <= 1'b1;
      if (r_state == CAPT && !w_marker) begin
        r_data <= w_word;
        r_col  <= r_ptr;
      end
    end
  always_comb begin
    col_rden  = r_state == READ ? 8'd1 << r_ptr : 8'd0;
    out_valid = r_state == SEND;
    busy      = r_state != IDLE && r_state != DONE;
    done      = r_state == DONE;
    out_data  = r_data;
    out_col   = r_col;
    err       = r_err;
  end
endmodule

// File: tb/tb_board_move_collector.sv
// tb_board_move_collector: directed checks of column ordering, backpressure, move limit and reset.
module tb_board_move_collector;
  logic clk = 0, reset = 1, start = 0, out_ready = 0, fclr = 0;
  logic [7:0] col_done = '0, col_rden;
  logic [383:0] col_data = '0;
  logic out_valid, busy, done, err;
  logic [47:0] out_data, special = '0;
  logic [2:0] out_col;
  int n_pass = 0, n_chk = 0, cyc = 0, viol = 0;
  int nmov[8], idx[8];
  logic [50:0] log_q[$];
  int hs_cyc[$];
  localparam logic [47:0] MARK = {8{6'd9}};

  board_move_collector dut (
    .clk(clk), .reset(reset), .start(start), .col_done(col_done), .col_data(col_data),
    .col_rden(col_rden), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mv(input int c, input int k);
    return {16'hBEEF, 8'(c), 24'(k)};
  endfunction

  // Column FIFO model with one-cycle read latency; word index nmov[c] onward is the end marker.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 8; c++)
      if (fclr) idx[c] <= 0;
      else if (col_rden[c]) begin
        col_data[48*c +: 48] <= (c == 0 && idx[c] == 0 && special != 0) ? special :
                                idx[c] < nmov[c] ? mv(c, idx[c]) : MARK;
        idx[c] <= idx[c] + 1;
      end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      log_q.push_back({out_col, out_data});
      hs_cyc.push_back(cyc);
    end
    if ((col_rden & ~col_done) != 8'd0) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step(1);
    start = 1;
    step(1);
    start = 0;
  endtask

  task automatic clear_fifo();
    fclr = 1;
    step(1);
    fclr = 0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int i = 0;
    while (!done && i < lim) begin step(1); i++; end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int i = 0;
    while (!out_valid && i < lim) begin step(1); i++; end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  function automatic int count_col(input int base, input int c);
    int n = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i][50:48] == 3'(c)) n++;
    return n;
  endfunction

  task automatic check_order(input string tag, input int base);
    chk({tag, "_n"}, 64'(log_q.size() - base), 64'd16);
    for (int k = 0; k < 16 && base + k < log_q.size(); k++)
      chk(tag, 64'(log_q[base+k]), 64'({3'(k / 2), mv(k / 2, k % 2)}));
  endtask

  initial begin
    int base, v0;
    for (int c = 0; c < 8; c++) nmov[c] = 2;
    fclr = 1;
    step(3);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rden", 64'(col_rden), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_col", 64'(out_col), 64'd0);
    reset = 0;
    fclr = 0;

    // All columns ready, two moves each, no backpressure.
    col_done = 8'hFF;
    out_ready = 1;
    base = log_q.size();
    pulse_start();
    chk("t29_busy", 64'(busy), 64'd1);
    wait_done("t29_done", 400);
    check_order("t29_mv", base);
    if (log_q.size() > base + 1) chk("t29_rate", 64'(hs_cyc[base+1] - hs_cyc[base]), 64'd3);
    chk("t29_err", 64'(err), 64'd0);
    chk("t29_idle", 64'(busy), 64'd0);

    // Backpressure: move held while out_ready is low.
    special = 48'h123456789ABC;
    clear_fifo();
    out_ready = 0;
    base = log_q.size();
    pulse_start();
    wait_valid("t31_valid", 50);
    for (int i = 0; i < 5; i++) begin
      chk("t31_hold", 64'(out_data), 64'(special));
      chk("t31_rden", 64'(col_rden), 64'd0);
      chk("t31_vld", 64'(out_valid), 64'd1);
      step(1);
    end
    out_ready = 1;
    wait_done("t31_done", 400);
    chk("t31_first", 64'(log_q[base]), 64'({3'd0, special}));
    chk("t31_n", 64'(log_q.size() - base), 64'd16);
    special = '0;

    // Done flags arrive 7..0; output must stay column-ordered, with a start pulse while busy.
    col_done = '0;
    clear_fifo();
    v0 = viol;
    base = log_q.size();
    pulse_start();
    for (int c = 7; c >= 0; c--) begin
      step(10);
      col_done[c] = 1;
      if (c == 4) begin
        pulse_start();
        chk("t30_busy", 64'(busy), 64'd1);
      end
    end
    wait_done("t30_done", 400);
    check_order("t30_mv", base);
    chk("t30_viol", 64'(viol - v0), 64'd0);

    // Column 3 exceeds the move limit.
    nmov[3] = 300;
    clear_fifo();
    base = log_q.size();
    pulse_start();
    wait_done("t32_done", 3000);
    chk("t32_col3", 64'(count_col(base, 3)), 64'd256);
    chk("t32_col4", 64'(count_col(base, 4)), 64'd2);
    chk("t32_col7", 64'(count_col(base, 7)), 64'd2);
    chk("t32_err", 64'(err), 64'd1);
    nmov[3] = 2;

    // Column 2 never completes: without a timeout the collector waits forever.
    col_done = 8'hFB;
    clear_fifo();
    base = log_q.size();
    pulse_start();
    chk("t33_err_clr", 64'(err), 64'd0);
    step(100);
    chk("t33_busy", 64'(busy), 64'd1);
    chk("t33_done", 64'(done), 64'd0);
    chk("t33_col1", 64'(count_col(base, 1)), 64'd2);
    chk("t33_col3", 64'(count_col(base, 3)), 64'd0);

    // Reset while a move waits in SEND, then a clean restart.
    reset = 1;
    step(1);
    reset = 0;
    col_done = 8'hFF;
    out_ready = 0;
    clear_fifo();
    pulse_start();
    wait_valid("t34_valid", 50);
    reset = 1;
    step(1);
    chk("t34_valid", 64'(out_valid), 64'd0);
    chk("t34_busy", 64'(busy), 64'd0);
    chk("t34_done", 64'(done), 64'd0);
    chk("t34_data", 64'(out_data), 64'd0);
    reset = 0;
    clear_fifo();
    out_ready = 1;
    base = log_q.size();
    pulse_start();
    wait_done("t34_done2", 400);
    check_order("t34_mv", base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
